// File: rtl/cache_flush_ctrl_pkg.sv
// Shared definitions for the per-bank flush sequencer: FSM states and line-index geometry.
package cache_flush_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE
  } flush_state_t;

  // Lines held by one bank for one way.
  function automatic int calc_lines(input int cache_size, input int line_size,
                                    input int num_banks, input int num_ways);
    return cache_size / (line_size * num_banks * num_ways);
  endfunction

  // A single-line bank still carries a 1-bit index.
  function automatic int calc_sel_bits(input int lines);
    return (lines > 1) ? $clog2(lines) : 1;
  endfunction

endpackage

// File: rtl/cache_flush_inflight.sv
// Up/down counter of flush ops accepted but not yet completed; saturates at zero.
// full reflects the registered count, empty reflects the count after this cycle's updates.
module cache_flush_inflight #(
  parameter int  MAX_INFLIGHT = 4,
  localparam int CW           = $clog2(MAX_INFLIGHT) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec_a,
  input  logic dec_b,
  output logic full,
  output logic empty
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [CW+1:0] up;
  logic [CW+1:0] down;
  logic          underflow;

  assign up        = {2'b00, cnt} + (CW+2)'(inc);
  assign down      = (CW+2)'(dec_a) + (CW+2)'(dec_b);
  assign underflow = down > up;
  // Stray writeback acks left over from an aborted flush must not wrap the count.
  assign cnt_nxt   = underflow ? '0 : CW'(up - down);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  assign full  = (cnt == CW'(MAX_INFLIGHT));
  assign empty = (cnt_nxt == '0);

  a_no_underflow: assert property (@(posedge clk) disable iff (!reset) !underflow);

endmodule

// File: rtl/cache_flush_ctrl.sv
// Per-bank flush sequencer: invalidates every tag after reset, then walks all (line, way) pairs on request.
// Ops are throttled by the inflight limit; outputs decode registered state, so op_ready never reaches op_valid.
module cache_flush_ctrl
  import cache_flush_ctrl_pkg::*;
#(
  parameter int  CACHE_SIZE    = 1024,
  parameter int  LINE_SIZE     = 16,
  parameter int  NUM_BANKS     = 1,
  parameter int  NUM_WAYS      = 1,
  parameter int  MAX_INFLIGHT  = 4,
  localparam int LINES         = calc_lines(CACHE_SIZE, LINE_SIZE, NUM_BANKS, NUM_WAYS),
  localparam int LINE_SEL_BITS = calc_sel_bits(LINES)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_req_valid,
  output logic                     flush_req_ready,
  output logic                     flush_done_valid,
  input  logic                     flush_done_ready,
  output logic                     core_lock,
  output logic                     init,
  output logic                     op_valid,
  input  logic                     op_ready,
  output logic [LINE_SEL_BITS-1:0] line_addr,
  output logic                     flush_line,
  output logic [NUM_WAYS-1:0]      flush_way_sel,
  input  logic                     op_rsp_valid,
  input  logic                     op_rsp_dirty,
  input  logic                     wb_ack
);

  localparam logic [NUM_WAYS-1:0] WAY0 = NUM_WAYS'(1);

  flush_state_t             state, state_nxt;
  logic [LINE_SEL_BITS-1:0] line_cnt, line_nxt;
  logic [NUM_WAYS-1:0]      way_oh, way_nxt;
  logic                     accept;
  logic                     last_line;
  logic                     last_way;
  logic                     infl_full;
  logic                     infl_empty;

  cache_flush_inflight #(
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) u_inflight (
    .clk   (clk),
    .reset (reset),
    .inc   (accept),
    .dec_a (op_rsp_valid & ~op_rsp_dirty),
    .dec_b (wb_ack),
    .full  (infl_full),
    .empty (infl_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_INIT;
      line_cnt <= '0;
      way_oh   <= WAY0;
    end else begin
      state    <= state_nxt;
      line_cnt <= line_nxt;
      way_oh   <= way_nxt;
    end
  end

  assign last_line = (line_cnt == LINE_SEL_BITS'(LINES - 1));
  // With a single way the one-hot is constant, so every accept moves to the next line.
  assign last_way  = way_oh[NUM_WAYS-1];
  assign accept    = op_valid & op_ready;

  always_comb begin
    state_nxt = state;
    line_nxt  = line_cnt;
    way_nxt   = way_oh;
    case (state)
      ST_INIT: begin
        line_nxt = line_cnt + LINE_SEL_BITS'(1);
        if (last_line) begin
          state_nxt = ST_IDLE;
          line_nxt  = '0;
        end
      end
      ST_IDLE: begin
        if (flush_req_valid) begin
          state_nxt = ST_FLUSH;
          line_nxt  = '0;
          way_nxt   = WAY0;
        end
      end
      ST_FLUSH: begin
        if (accept) begin
          if (last_way) begin
            way_nxt  = WAY0;
            line_nxt = line_cnt + LINE_SEL_BITS'(1);
            if (last_line) begin
              state_nxt = ST_DRAIN;
              line_nxt  = '0;
            end
          end else begin
            way_nxt = way_oh << 1;
          end
        end
      end
      ST_DRAIN: begin
        if (infl_empty) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (flush_done_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // init is masked while reset is held so the bank sees no strobe until the walk actually starts.
  assign init             = (state == ST_INIT) & reset;
  assign flush_req_ready  = (state == ST_IDLE);
  assign flush_done_valid = (state == ST_DONE);
  assign core_lock        = (state == ST_INIT) | (state == ST_FLUSH) | (state == ST_DRAIN);
  assign op_valid         = (state == ST_FLUSH) & ~infl_full;
  assign flush_line       = op_valid;
  assign line_addr        = ((state == ST_INIT) | (state == ST_FLUSH)) ? line_cnt : '0;
  assign flush_way_sel    = (state == ST_FLUSH) ? way_oh : '0;

endmodule

// File: tb/tb_cache_flush_ctrl.sv
// Directed bench for cache_flush_ctrl with a 32-line, 2-way bank and a 1-cycle response pipeline model.
module tb_cache_flush_ctrl;

  localparam int NOPS = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush_req_valid = 1'b0;
  logic       flush_req_ready;
  logic       flush_done_valid;
  logic       flush_done_ready = 1'b0;
  logic       core_lock;
  logic       init;
  logic       op_valid;
  logic       op_ready = 1'b0;
  logic [4:0] line_addr;
  logic       flush_line;
  logic [1:0] flush_way_sel;
  logic       op_rsp_valid = 1'b0;
  logic       op_rsp_dirty = 1'b0;
  logic       wb_ack = 1'b0;

  cache_flush_ctrl #(
    .CACHE_SIZE   (1024),
    .LINE_SIZE    (16),
    .NUM_BANKS    (1),
    .NUM_WAYS     (2),
    .MAX_INFLIGHT (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .flush_req_valid  (flush_req_valid),
    .flush_req_ready  (flush_req_ready),
    .flush_done_valid (flush_done_valid),
    .flush_done_ready (flush_done_ready),
    .core_lock        (core_lock),
    .init             (init),
    .op_valid         (op_valid),
    .op_ready         (op_ready),
    .line_addr        (line_addr),
    .flush_line       (flush_line),
    .flush_way_sel    (flush_way_sel),
    .op_rsp_valid     (op_rsp_valid),
    .op_rsp_dirty     (op_rsp_dirty),
    .wb_ack           (wb_ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Pipeline model state, advanced once per falling edge by tick().
  int         cyc = 0;
  int         ready_mode = 0;
  bit         dirty_mode = 1'b0;
  logic       acc_prev = 1'b0;
  logic       stalled_prev = 1'b0;
  logic [4:0] prev_line = '0;
  logic [1:0] prev_way = '0;
  int         n_acc = 0;
  int         n_rsp = 0;
  int         n_stall = 0;
  int         last_acc = -1;
  int         stall_viol = 0;
  logic [4:0] log_line[$];
  logic [1:0] log_way[$];

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (op_rsp_valid) n_rsp++;
    if (stalled_prev && (op_valid !== 1'b1 || line_addr !== prev_line || flush_way_sel !== prev_way))
      stall_viol++;
    op_rsp_valid = acc_prev;
    op_rsp_dirty = acc_prev & dirty_mode;
    case (ready_mode)
      0:       op_ready = 1'b0;
      1:       op_ready = 1'b1;
      default: op_ready = 1'($urandom_range(0, 1));
    endcase
    acc_prev     = op_valid & op_ready;
    stalled_prev = op_valid & ~op_ready;
    if (stalled_prev) n_stall++;
    prev_line = line_addr;
    prev_way  = flush_way_sel;
    if (acc_prev) begin
      log_line.push_back(line_addr);
      log_way.push_back(flush_way_sel);
      n_acc++;
      last_acc = cyc;
    end
  endtask

  task automatic clear_log();
    log_line.delete();
    log_way.delete();
    n_acc = 0; n_rsp = 0; n_stall = 0; last_acc = -1; stall_viol = 0;
    acc_prev = 1'b0; stalled_prev = 1'b0;
  endtask

  task automatic test_reset();
    int errs;
    #1 reset = 1'b0;
    #3;
    n_checks++;
    if ({init, op_valid, flush_line, flush_req_ready, flush_done_valid} !== 5'b0 || core_lock !== 1'b1 ||
        line_addr !== 5'd0 || flush_way_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: init=%b op_valid=%b req_rdy=%b done=%b lock=%b line=%0d way=%b, need all 0 and lock=1",
               init, op_valid, flush_req_ready, flush_done_valid, core_lock, line_addr, flush_way_sel);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    errs = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (init !== 1'b1 || line_addr !== 5'(i) || core_lock !== 1'b1 || flush_req_ready !== 1'b0) errs++;
    end
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL init_walk: %0d of 32 cycles wrong, need init=1 with line_addr 0..31", errs);
    end
    tick();
    n_checks++;
    if (init !== 1'b0 || flush_req_ready !== 1'b1 || core_lock !== 1'b0) begin
      n_fail++;
      $display("FAIL init_to_idle: init=%b req_rdy=%b lock=%b, need 0 1 0", init, flush_req_ready, core_lock);
    end
  endtask

  task automatic test_flush_clean();
    bit got; int rdy_during; int lock_err; int fl_err; int errs;
    ready_mode = 1; dirty_mode = 1'b0; clear_log();
    tick();
    flush_req_valid = 1'b1;   // held through the flush: must be ignored until IDLE
    got = 1'b0; rdy_during = 0; lock_err = 0; fl_err = 0;
    for (int c = 0; c < 300 && !got; c++) begin
      tick();
      if (flush_line !== op_valid) fl_err++;
      if (flush_done_valid === 1'b1) got = 1'b1;
      else begin
        if (flush_req_ready !== 1'b0) rdy_during++;
        if (core_lock !== 1'b1) lock_err++;
      end
    end
    flush_req_valid = 1'b0;
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL clean_done_seen: no flush_done_valid within 300 cycles"); end
    errs = 0;
    for (int i = 0; i < log_line.size(); i++)
      if (log_line[i] !== 5'(i / 2) || log_way[i] !== 2'(1 << (i % 2))) errs++;
    n_checks++;
    if (n_acc != NOPS || errs != 0) begin
      n_fail++; $display("FAIL clean_order: %0d ops with %0d out of order, need 64 in line-major order", n_acc, errs);
    end
    n_checks++;
    if (cyc - last_acc != 2) begin
      n_fail++; $display("FAIL clean_done_latency: done %0d cycles after last accept, need 2", cyc - last_acc);
    end
    n_checks++;
    if (rdy_during != 0 || lock_err != 0 || fl_err != 0 || core_lock !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_handshake: req_rdy_hi=%0d lock_lo=%0d flush_line_err=%0d lock_in_done=%b, need 0 0 0 0",
               rdy_during, lock_err, fl_err, core_lock);
    end
    flush_done_ready = 1'b1;
    tick();
    flush_done_ready = 1'b0;
    n_checks++;
    if (flush_done_valid !== 1'b0 || flush_req_ready !== 1'b1 || op_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_back_to_idle: done=%b req_rdy=%b op_valid=%b, need 0 1 0", flush_done_valid, flush_req_ready, op_valid);
    end
  endtask

  task automatic test_dirty_backpressure();
    bit got; int acks; int acks_at_done; int errs;
    ready_mode = 1; dirty_mode = 1'b1; clear_log();
    tick(); flush_req_valid = 1'b1;
    tick(); flush_req_valid = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    n_checks++;
    if (n_acc != 4 || op_valid !== 1'b0) begin
      n_fail++; $display("FAIL dirty_limit: %0d accepts op_valid=%b, need 4 accepts and op_valid=0", n_acc, op_valid);
    end
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    n_checks++;
    if (n_acc != 5 || last_acc != cyc) begin
      n_fail++; $display("FAIL dirty_one_ack_accept: %0d accepts last at %0d now %0d, need 5 accepts this cycle", n_acc, last_acc, cyc);
    end
    tick();
    n_checks++;
    if (op_valid !== 1'b0 || n_acc != 5) begin
      n_fail++; $display("FAIL dirty_one_ack_only: op_valid=%b accepts=%0d, need 0 and 5", op_valid, n_acc);
    end
    acks = 1; acks_at_done = -1; got = 1'b0;
    for (int c = 0; c < 2000 && !got; c++) begin
      tick();
      if (flush_done_valid === 1'b1) begin
        got = 1'b1; acks_at_done = acks; wb_ack = 1'b0;
      end else begin
        wb_ack = (acks < n_rsp);
        if (wb_ack) acks++;
      end
    end
    wb_ack = 1'b0;
    n_checks++;
    if (!got || acks_at_done != NOPS) begin
      n_fail++; $display("FAIL dirty_done_after_acks: done=%b after %0d acks, need done after exactly 64 acks", got, acks_at_done);
    end
    errs = 0;
    for (int i = 0; i < log_line.size(); i++)
      if (log_line[i] !== 5'(i / 2) || log_way[i] !== 2'(1 << (i % 2))) errs++;
    n_checks++;
    if (n_acc != NOPS || errs != 0) begin
      n_fail++; $display("FAIL dirty_order: %0d ops with %0d out of order, need 64 in order", n_acc, errs);
    end
    dirty_mode = 1'b0;
    flush_done_ready = 1'b1;
    tick();
    flush_done_ready = 1'b0;
  endtask

  task automatic test_random_stall();
    bit got; int errs;
    ready_mode = 2; dirty_mode = 1'b0; clear_log();
    tick(); flush_req_valid = 1'b1;
    tick(); flush_req_valid = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 1000 && !got; c++) begin
      tick();
      if (flush_done_valid === 1'b1) got = 1'b1;
    end
    errs = 0;
    for (int i = 0; i < log_line.size(); i++)
      if (log_line[i] !== 5'(i / 2) || log_way[i] !== 2'(1 << (i % 2))) errs++;
    n_checks++;
    if (!got || n_acc != NOPS || errs != 0) begin
      n_fail++; $display("FAIL stall_order: done=%b ops=%0d misordered=%0d, need done with 64 ordered ops", got, n_acc, errs);
    end
    n_checks++;
    if (stall_viol != 0 || n_stall == 0) begin
      n_fail++; $display("FAIL stall_stable: %0d unstable stalls over %0d stalls, need 0 over a nonzero count", stall_viol, n_stall);
    end
    ready_mode = 1;
    flush_done_ready = 1'b1;
    tick();
    flush_done_ready = 1'b0;
  endtask

  task automatic test_same_cycle_dec();
    bit got;
    ready_mode = 1; dirty_mode = 1'b1; clear_log();
    tick(); flush_req_valid = 1'b1;
    tick(); flush_req_valid = 1'b0;  // op0 accepted
    tick(); dirty_mode = 1'b0;       // op0 answers dirty, op1 accepted
    tick(); wb_ack = 1'b1;           // op1 clean + op2 accept + op0 writeback ack together
    n_checks++;
    if (last_acc != cyc || n_acc != 3) begin
      n_fail++; $display("FAIL same_cycle_setup: accepts=%0d last=%0d now=%0d, need 3 with one this cycle", n_acc, last_acc, cyc);
    end
    tick(); wb_ack = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      tick();
      if (flush_done_valid === 1'b1) got = 1'b1;
    end
    n_checks++;
    if (!got || n_acc != NOPS || cyc - last_acc != 2) begin
      n_fail++;
      $display("FAIL same_cycle_net: done=%b ops=%0d done %0d cycles after last accept, need 1, 64, 2",
               got, n_acc, cyc - last_acc);
    end
    flush_done_ready = 1'b1;
    tick();
    flush_done_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    bit got; int errs; int guard;
    ready_mode = 1; dirty_mode = 1'b0; clear_log();
    tick(); flush_req_valid = 1'b1;
    tick(); flush_req_valid = 1'b0;
    guard = 0;
    while (n_acc < 17 && guard < 100) begin tick(); guard++; end
    reset = 1'b0;
    ready_mode = 0; op_ready = 1'b0; op_rsp_valid = 1'b0; acc_prev = 1'b0; stalled_prev = 1'b0;
    #1;
    n_checks++;
    if (n_acc != 17 || init !== 1'b0 || core_lock !== 1'b1 || op_valid !== 1'b0 ||
        line_addr !== 5'd0 || flush_way_sel !== 2'd0 || flush_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_outputs: accepts=%0d init=%b lock=%b op_valid=%b line=%0d way=%b req_rdy=%b, need 17 0 1 0 0 00 0",
               n_acc, init, core_lock, op_valid, line_addr, flush_way_sel, flush_req_ready);
    end
    tick(); tick();
    reset = 1'b1;
    #1;
    errs = (init !== 1'b1 || line_addr !== 5'd0) ? 1 : 0;
    for (int i = 1; i < 32; i++) begin
      tick();
      if (init !== 1'b1 || line_addr !== 5'(i)) errs++;
    end
    tick();
    n_checks++;
    if (errs != 0 || flush_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort_reinit: %0d bad init cycles req_rdy=%b, need 0 and 1", errs, flush_req_ready);
    end
    ready_mode = 1; clear_log();
    tick(); flush_req_valid = 1'b1;
    tick(); flush_req_valid = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      tick();
      if (flush_done_valid === 1'b1) got = 1'b1;
    end
    errs = 0;
    for (int i = 0; i < log_line.size(); i++)
      if (log_line[i] !== 5'(i / 2) || log_way[i] !== 2'(1 << (i % 2))) errs++;
    n_checks++;
    if (!got || n_acc != NOPS || errs != 0) begin
      n_fail++; $display("FAIL abort_reflush: done=%b ops=%0d misordered=%0d, need done with 64 ordered ops", got, n_acc, errs);
    end
    errs = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (flush_done_valid !== 1'b1) errs++;
    end
    n_checks++;
    if (errs != 0) begin
      n_fail++; $display("FAIL done_hold: done dropped in %0d of 5 held cycles, need 0", errs);
    end
    flush_done_ready = 1'b1;
    tick();
    flush_done_ready = 1'b0;
    n_checks++;
    if (flush_done_valid !== 1'b0 || flush_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL done_release: done=%b req_rdy=%b, need 0 1", flush_done_valid, flush_req_ready);
    end
  endtask

  initial begin
    test_reset();
    test_flush_clean();
    test_dirty_backpressure();
    test_random_stall();
    test_same_cycle_dec();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_flush_ctrl.md
Name: cache_flush_ctrl

Overview:
- Per-bank sequencer sitting directly upstream of the cache tag store.
- After reset it walks every line index asserting `init` to invalidate the tags.
- On a flush request it walks every (line, way) pair, presenting `flush_line`/`flush_way_sel` into the bank pipeline.
- It tracks per-op completion (clean line, or dirty line whose writeback was acked) and signals flush done; it gates core requests while active.

Parameters:
- CACHE_SIZE, 1024, cache size in bytes
- LINE_SIZE, 16, line size in bytes
- NUM_BANKS, 1, number of banks
- NUM_WAYS, 1, associativity
- MAX_INFLIGHT, 4, max flush ops accepted but not yet completed (power of 2, ≥1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- flush_req_valid  in  1  flush request
- flush_req_ready  out  1  high only in IDLE
- flush_done_valid  out  1  flush complete
- flush_done_ready  in  1  done consumer ready
- core_lock  out  1  high in INIT, FLUSH and DRAIN states: bank must not accept core requests
- init  out  1  tag/data invalidate strobe
- op_valid  out  1  flush op presented to pipeline
- op_ready  in  1  pipeline accept (~stall)
- line_addr  out  LINE_SEL_BITS  line index for init/flush
- flush_line  out  1  equals op_valid
- flush_way_sel  out  NUM_WAYS  one-hot way of current flush op
- op_rsp_valid  in  1  tag-stage result for an accepted flush op
- op_rsp_dirty  in  1  result was an eviction (writeback will follow)
- wb_ack  in  1  memory acknowledged one writeback

Behaviour:
- LINES = CACHE_SIZE/(LINE_SIZE·NUM_BANKS·NUM_WAYS); LINE_SEL_BITS = clog2(LINES), min 1.
- States: INIT, IDLE, FLUSH, DRAIN, DONE.
- Async reset (reset=0):
  - state=INIT, line counter=0, way one-hot=1, inflight=0.
  - All outputs 0 except core_lock=1.
- INIT: `init`=1, `line_addr`=line counter; advance 1 line/cycle ignoring `op_ready` (tag writes on init are not stall-gated). After line LINES-1 → IDLE, counter=0.
- IDLE:
  - `flush_req_ready`=1.
  - On `flush_req_valid` → FLUSH, counters at 0 / way 1.
  - A request arriving during INIT/FLUSH/DRAIN/DONE is held off (`ready`=0).
- FLUSH:
  - `op_valid` = (inflight < MAX_INFLIGHT); `line_addr`=line counter; `flush_way_sel`=way one-hot.
  - On `op_valid && op_ready`: way rotates left. When the way wraps, line increments.
  - Order is line-major, way-minor: (0,w0),(0,w1),…,(LINES-1,wN-1).
  - Acceptance of the last pair → DRAIN.
  - `op_valid`, `line_addr` and `flush_way_sel` stay stable while `op_ready`=0.
- inflight counter (width clog2(MAX_INFLIGHT)+1):
  - +1 on op accept.
  - −1 on (`op_rsp_valid && !op_rsp_dirty`) and −1 on `wb_ack`.
  - Same-cycle increment and decrement net to 0, or −1 when both decrements fire.
  - Underflow is an assertion failure (sim only). Never exceeds MAX_INFLIGHT.
- DRAIN: wait inflight==0 → DONE.
- DONE: `flush_done_valid`=1 until `flush_done_ready`, then IDLE the following cycle. `core_lock`=0 in DONE and IDLE.
- NUM_WAYS=1: way one-hot constant 1; every accept increments line.
- Reset asserted mid-FLUSH/DRAIN: immediate abort, return to INIT. Pending `wb_ack`s after reset are ignored (counter held ≥0 by saturation at 0).
- All outputs registered-state decodes; no combinational path from `op_ready` to `op_valid`.

Decomposition:
- Shared cache package:
  - state enum (INIT, IDLE, FLUSH, DRAIN, DONE)
  - LINES / LINE_SEL_BITS derivation consistent with existing per-bank line macros
- One sub-module, `cache_flush_inflight`: up/down saturating counter with inc, dec_a, dec_b, outputs full and empty.
- Line/way iteration stays in the top.

Test Plan (CACHE_SIZE=1024, LINE_SIZE=16, NUM_BANKS=1, NUM_WAYS=2 → LINES=32):
- Release reset, hold `op_ready`=0 → `init`=1 for exactly 32 cycles with `line_addr` 0..31, then `flush_req_ready`=1, `core_lock`=0.
- Flush with `op_ready`=1, every response clean 1 cycle after accept:
  - 64 ops in order (0,01),(0,10),(1,01)…(31,10)
  - `flush_done_valid` asserted 2 cycles after the last accept
- Every response dirty, `wb_ack` withheld:
  - `op_valid` drops after 4 accepts
  - one `wb_ack` → exactly one more accept next cycle
  - done only after 64 acks
- Toggle `op_ready` randomly → no op skipped or duplicated; `line_addr`/`flush_way_sel` stable while stalled.
- Same-cycle accept + clean response + `wb_ack` → inflight changes by −1; verify via the done timing.
- Assert reset mid-flush at op 17 → INIT restarts at line 0; a new flush completes with all 64 ops; `flush_done_ready`=0 holds `done_valid` for 5 cycles.
